bg_tile_scanline_gen: RTL and testbench

- Parametrised successor to the fixed 3-plane BG scanline generator.
- Per 8-pixel column it fetches the name-table entry, then fetches tile pattern data through a req/ack port. That port can share one tile ROM across several layers via an external arbiter.
- It shifts out pixels with horizontal and vertical flip support.
- It produces palette-bank plus pixel-colour output into the colour mixer, one pixel per VCLK.

---
 rtl/bg_tile_pkg.sv | 28 ++
 rtl/bg_plane_shifter.sv | 36 +++
 rtl/bg_tile_scanline_gen.sv | 155 +++++++++++++++
 tb/tb_bg_tile_scanline_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/bg_tile_pkg.sv
// Shared definitions for the tile-based background scanline generator:
// fetch states, name-entry field positions and the tile-row helpers.
package bg_tile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NAME = 2'd1,
        TREQ = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int CODE_LSB  = 0;
    localparam int HFLIP_BIT = 10;
    localparam int VFLIP_BIT = 11;
    localparam int PAL_LSB   = 12;

    localparam int TILE_W = 8;

    // Mirrors a tile row so the rightmost pixel becomes the first one shifted out.
    function automatic logic [TILE_W-1:0] byte_rev(input logic [TILE_W-1:0] b);
        logic [TILE_W-1:0] r;
        for (int i = 0; i < TILE_W; i++) begin
            r[i] = b[TILE_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bg_plane_shifter.sv
// One bit-plane of the pixel pipeline: loads a tile row (optionally mirrored)
// and shifts it left one pixel per clock; the MSB is the current pixel.
module bg_plane_shifter
    import bg_tile_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              hflip_i,
    input  logic [TILE_W-1:0] data_i,
    output logic              msb_o
);

    logic [TILE_W-1:0] sr_q;
    logic [TILE_W-1:0] sr_d;

    always_comb begin
        if (load_i) begin
            sr_d = hflip_i ? byte_rev(data_i) : data_i;
        end else begin
            sr_d = {sr_q[TILE_W-2:0], 1'b0};
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_o = sr_q[TILE_W-1];

endmodule

// File: rtl/bg_tile_scanline_gen.sv
// Background tile layer: prefetches the next 8-pixel column (name entry, then
// pattern data over req/ack) and shifts out {palette, colour} per VCLK.
module bg_tile_scanline_gen
    import bg_tile_pkg::*;
#(
    parameter int PLANES = 3,
    parameter int CODE_W = 10,
    parameter int PAL_W  = 4,
    parameter int LATE_W = 8
) (
    input  logic                     VCLK,
    input  logic                     RESET,
    input  logic [8:0]               HP,
    input  logic [8:0]               VP,
    output logic [9:0]               VRAMAD,
    input  logic [15:0]              VRAMDT,
    output logic [CODE_W+2:0]        TILEAD,
    output logic                     TILE_REQ,
    input  logic                     TILE_ACK,
    input  logic [TILE_W*PLANES-1:0] TILEDT,
    output logic [PAL_W+PLANES-1:0]  OPIX,
    output logic                     OTRANS,
    output logic                     LATE,
    output logic [LATE_W-1:0]        LATE_CNT
);

    state_e                     state_q, state_d;
    logic [9:0]                 vramad_q, vramad_d;
    logic [CODE_W+2:0]          tilead_q, tilead_d;
    logic                       req_q, req_d;
    logic                       pend_hflip_q, pend_hflip_d;
    logic [PAL_W-1:0]           pend_pal_q, pend_pal_d;
    logic [TILE_W*PLANES-1:0]   pref_q, pref_d;
    logic [PAL_W-1:0]           pal_q, pal_d;
    logic                       late_q, late_d;
    logic [LATE_W-1:0]          late_cnt_q, late_cnt_d;

    logic                       load;
    logic [TILE_W*PLANES-1:0]   load_data;
    logic [PLANES-1:0]          colour;
    logic [4:0]                 next_col;
    logic                       unused_pos;

    assign next_col   = HP[7:3] + 5'd1;
    assign unused_pos = ^{HP[8], VP[8]};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        vramad_d     = vramad_q;
        tilead_d     = tilead_q;
        req_d        = req_q;
        pend_hflip_d = pend_hflip_q;
        pend_pal_d   = pend_pal_q;
        pref_d       = pref_q;
        pal_d        = pal_q;
        late_d       = 1'b0;
        late_cnt_d   = late_cnt_q;
        load         = 1'b0;
        load_data    = '0;

        if (HP[2:0] == 3'd7) begin
            // Column boundary: whatever the fetch has reached, the next column starts now.
            load    = 1'b1;
            state_d = IDLE;
            req_d   = 1'b0;
            if (state_q == DONE) begin
                load_data = pref_q;
                pal_d     = pend_pal_q;
            end else if (state_q == TREQ && TILE_ACK) begin
                load_data = TILEDT;
                pal_d     = pend_pal_q;
            end else begin
                late_d = 1'b1;
                if (late_cnt_q != '1) begin
                    late_cnt_d = late_cnt_q + LATE_W'(1);
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (HP[2:0] == 3'd0) begin
                        vramad_d = {VP[7:3], next_col};
                        state_d  = NAME;
                    end
                end
                NAME: begin
                    pend_hflip_d = VRAMDT[HFLIP_BIT];
                    pend_pal_d   = VRAMDT[PAL_LSB +: PAL_W];
                    tilead_d     = {VRAMDT[CODE_LSB +: CODE_W], VP[2:0] ^ {3{VRAMDT[VFLIP_BIT]}}};
                    req_d        = 1'b1;
                    state_d      = TREQ;
                end
                TREQ: begin
                    if (TILE_ACK) begin
                        pref_d  = TILEDT;
                        req_d   = 1'b0;
                        state_d = DONE;
                    end
                end
                DONE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge VCLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            vramad_q     <= '0;
            tilead_q     <= '0;
            req_q        <= 1'b0;
            pend_hflip_q <= 1'b0;
            pend_pal_q   <= '0;
            pref_q       <= '0;
            pal_q        <= '0;
            late_q       <= 1'b0;
            late_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            vramad_q     <= vramad_d;
            tilead_q     <= tilead_d;
            req_q        <= req_d;
            pend_hflip_q <= pend_hflip_d;
            pend_pal_q   <= pend_pal_d;
            pref_q       <= pref_d;
            pal_q        <= pal_d;
            late_q       <= late_d;
            late_cnt_q   <= late_cnt_d;
        end
    end

    for (genvar p = 0; p < PLANES; p++) begin : g_plane
        bg_plane_shifter u_shifter (
            .clk_i   (VCLK),
            .rst_i   (RESET),
            .load_i  (load),
            .hflip_i (pend_hflip_q),
            .data_i  (load_data[p*TILE_W +: TILE_W]),
            .msb_o   (colour[p])
        );
    end

    assign VRAMAD   = vramad_q;
    assign TILEAD   = tilead_q;
    assign TILE_REQ = req_q;
    assign OPIX     = {pal_q, colour};
    assign OTRANS   = (colour == '0);
    assign LATE     = late_q;
    assign LATE_CNT = late_cnt_q;

endmodule

// File: tb/tb_bg_tile_scanline_gen.sv
// Directed bench for bg_tile_scanline_gen: aligned fetch, flips, late fetch,
// same-cycle bypass, column wrap, counter saturation and reset mid-request.
module tb_bg_tile_scanline_gen;

    logic        VCLK;
    logic        RESET;
    logic [8:0]  HP;
    logic [8:0]  VP;
    logic [9:0]  VRAMAD;
    logic [15:0] VRAMDT;
    logic [12:0] TILEAD;
    logic        TILE_REQ;
    logic        TILE_ACK;
    logic [23:0] TILEDT;
    logic [6:0]  OPIX;
    logic        OTRANS;
    logic        LATE;
    logic [7:0]  LATE_CNT;

    int n_tests = 0;
    int n_fail  = 0;

    bg_tile_scanline_gen dut (
        .VCLK     (VCLK),
        .RESET    (RESET),
        .HP       (HP),
        .VP       (VP),
        .VRAMAD   (VRAMAD),
        .VRAMDT   (VRAMDT),
        .TILEAD   (TILEAD),
        .TILE_REQ (TILE_REQ),
        .TILE_ACK (TILE_ACK),
        .TILEDT   (TILEDT),
        .OPIX     (OPIX),
        .OTRANS   (OTRANS),
        .LATE     (LATE),
        .LATE_CNT (LATE_CNT)
    );

    initial VCLK = 1'b0;
    always #5 VCLK = ~VCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One VCLK edge consumes the current HP; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge VCLK);
        #1;
        HP = HP + 9'd1;
    endtask

    initial begin
        RESET    = 1'b1;
        HP       = 9'h010;
        VP       = 9'h023;
        VRAMDT   = 16'h3005;
        TILE_ACK = 1'b0;
        TILEDT   = '0;
        @(posedge VCLK); #1;
        @(posedge VCLK); #1;

        check("rst_req",     TILE_REQ, 0);
        check("rst_vramad",  VRAMAD,   0);
        check("rst_tilead",  TILEAD,   0);
        check("rst_opix",    OPIX,     0);
        check("rst_otrans",  OTRANS,   1);
        check("rst_late",    LATE,     0);
        check("rst_latecnt", LATE_CNT, 0);
        RESET = 1'b0;

        // Aligned fetch: entry 3005 at VP=0x23, ACK two cycles after REQ.
        tick();
        check("al_vramad", VRAMAD, 10'h083);
        tick();
        check("al_tilead", TILEAD, 13'h02B);
        check("al_req_up", TILE_REQ, 1);
        tick();
        tick();
        TILE_ACK = 1'b1;
        TILEDT   = 24'hFF0FF0;
        tick();
        TILE_ACK = 1'b0;
        TILEDT   = '0;
        check("al_req_dn", TILE_REQ, 0);
        tick();
        tick();
        tick();
        check("al_late0", LATE, 0);

        // Shows the aligned column while the next fetch is starved of ACK.
        for (int i = 0; i < 8; i++) begin
            check("al_pix", OPIX, (i < 4) ? 7'h1D : 7'h1E);
            check("al_otrans", OTRANS, 0);
            if (i == 7) check("lt_req_held", TILE_REQ, 1);
            tick();
        end
        check("lt_pulse", LATE, 1);
        check("lt_cnt1",  LATE_CNT, 1);
        check("lt_req_dn", TILE_REQ, 0);

        // Late column displays transparent; meanwhile fetch a flipped entry.
        VP     = 9'h022;
        VRAMDT = 16'h0C01;
        for (int i = 0; i < 8; i++) begin
            check("lt_otrans", OTRANS, 1);
            if (i == 1) check("lt_pulse_end", LATE, 0);
            if (i == 2) check("fl_vramad", VRAMAD, 10'h085);
            if (i == 2) check("fl_tilead", TILEAD, 13'h00D);
            TILE_ACK = (i == 3);
            TILEDT   = (i == 3) ? 24'h000080 : 24'h000000;
            tick();
        end
        TILE_ACK = 1'b0;
        TILEDT   = '0;
        check("fl_late0", LATE, 0);

        // Mirrored column; the following fetch gets its ACK on the load edge.
        VRAMDT = 16'h5003;
        for (int i = 0; i < 8; i++) begin
            check("fl_pix", OPIX, (i == 7) ? 7'h01 : 7'h00);
            TILE_ACK = (i == 7);
            TILEDT   = (i == 7) ? 24'h0000FF : 24'h000000;
            tick();
        end
        TILE_ACK = 1'b0;
        TILEDT   = '0;
        check("by_pix",    OPIX, 7'h29);
        check("by_late0",  LATE, 0);
        check("by_latecnt", LATE_CNT, 1);

        // 256 starved columns push the late counter into saturation.
        for (int i = 0; i < 2048; i++) begin
            tick();
        end
        check("sat_cnt", LATE_CNT, 8'hFF);

        // Column 31 prefetches column 0.
        HP = 9'h0F8;
        tick();
        check("wrap_vramad", VRAMAD, 10'h080);
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        check("sat_pulse", LATE, 1);
        check("sat_hold",  LATE_CNT, 8'hFF);

        // Reset while a request is outstanding.
        VRAMDT = 16'h3005;
        tick();
        tick();
        check("rq_req_up", TILE_REQ, 1);
        #2;
        RESET = 1'b1;
        #1;
        check("rq_req_async", TILE_REQ, 0);
        check("rq_opix",      OPIX, 0);
        check("rq_otrans",    OTRANS, 1);
        check("rq_latecnt",   LATE_CNT, 0);
        @(posedge VCLK); #1;
        RESET = 1'b0;
        HP    = 9'h104;
        tick();
        tick();
        check("rq_idle_req",    TILE_REQ, 0);
        check("rq_idle_vramad", VRAMAD, 0);
        tick();
        tick();
        check("rq_hp_late", LATE_CNT, 1);
        tick();
        check("rq_restart_vramad", VRAMAD, 10'h082);
        tick();
        check("rq_restart_req",    TILE_REQ, 1);
        check("rq_restart_tilead", TILEAD, 13'h02A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
